// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, FSM states and op classification helpers for the multi-cycle ALU
package alu_pkg;
   localparam int ALU_WIDTH_DEFAULT = 32;
   typedef enum logic [3:0] {
      OP_AND  = 4'b0000,
      OP_OR   = 4'b0001,
      OP_ADD  = 4'b0010,
      OP_XOR  = 4'b0011,
      OP_SLL  = 4'b0100,
      OP_SRL  = 4'b0101,
      OP_SUB  = 4'b0110,
      OP_SRA  = 4'b0111,
      OP_SLT  = 4'b1000,
      OP_SLTU = 4'b1001
   } alu_op_t;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   function automatic logic is_shift_op(input logic [3:0] op);
      return op inside {OP_SLL, OP_SRL, OP_SRA};
   endfunction
   function automatic logic is_legal_op(input logic [3:0] op);
      return op inside {OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SLL, OP_SRL, OP_SUB, OP_SRA, OP_SLT, OP_SLTU};
   endfunction
endpackage

// File: rtl/alu_comb.sv
// alu_comb: combinational logic/arith/compare unit with a single-step shifter
module alu_comb import alu_pkg::*; #(
   parameter int WIDTH = ALU_WIDTH_DEFAULT,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic [3:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [SHAMT_W-1:0] amt,
   output logic [WIDTH-1:0]   y
);
   // SRA keeps the operand MSB, so iterating on a partial result preserves the original sign
   always_comb begin
      y = '0;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_ADD:  y = a + b;
         OP_SUB:  y = a - b;
         OP_SLT:  y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         OP_SLTU: y = {{(WIDTH-1){1'b0}}, a < b};
         OP_SLL:  y = a << amt;
         OP_SRL:  y = a >> amt;
         OP_SRA:  y = $signed(a) >>> amt;
         default: y = '0;
      endcase
   end
endmodule

// File: rtl/alu_multicycle_sva.sv
// alu_multicycle_sva: clocked protocol and result checks bound onto alu_multicycle
module alu_multicycle_sva import alu_pkg::*; #(
   parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
   input logic             clk,
   input logic             rst,
   input logic             in_valid,
   input logic             in_ready,
   input logic [3:0]       alu_op,
   input logic [WIDTH-1:0] in_a,
   input logic [WIDTH-1:0] in_b,
   input logic             out_valid,
   input logic             out_ready,
   input logic [WIDTH-1:0] result,
   input logic             zero,
   input logic             illegal_op,
   input logic             in_shift
);
   localparam int SHAMT_W = $clog2(WIDTH);
   logic [WIDTH-1:0] exp_r;
   function automatic logic [WIDTH-1:0] ref_alu(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [SHAMT_W-1:0] s;
      s = b[SHAMT_W-1:0];
      case (op)
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_SLT:  return {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         OP_SLTU: return {{(WIDTH-1){1'b0}}, a < b};
         OP_SLL:  return a << s;
         OP_SRL:  return a >> s;
         OP_SRA:  return $signed(a) >>> s;
         default: return '0;
      endcase
   endfunction
   // reference result captured whenever an operation is accepted
   always_ff @(posedge clk) begin
      if (!rst && in_valid && in_ready) exp_r <= ref_alu(alu_op, in_a, in_b);
   end
   a_zero: assert property (@(posedge clk) zero == (result == '0));
   a_hold: assert property (@(posedge clk) disable iff (rst) out_valid && !out_ready |=> $stable(result));
   a_busy: assert property (@(posedge clk) in_shift |-> !in_ready);
   a_illegal: assert property (@(posedge clk) disable iff (rst) out_valid && illegal_op |-> result == '0);
   a_model: assert property (@(posedge clk) disable iff (rst) out_valid |-> result == exp_r);
endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: registered ALU with valid/ready handshakes and an iterative shifter
module alu_multicycle import alu_pkg::*; #(
   parameter int WIDTH = ALU_WIDTH_DEFAULT,
   parameter int SHIFT_STEP = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal_op
);
   localparam int SHAMT_W = $clog2(WIDTH);
   localparam logic [SHAMT_W-1:0] STEP = SHAMT_W'(SHIFT_STEP);
   state_t state;
   logic [WIDTH-1:0] work, y, c_a;
   logic [SHAMT_W-1:0] rem, step, shamt, c_amt;
   logic [3:0] op_r, c_op;
   logic in_shift, accept;
   assign in_shift = state == SHIFT;
   assign in_ready = !rst && (state == IDLE || (state == DONE && out_ready));
   assign out_valid = state == DONE;
   assign zero = result == '0;
   assign accept = in_valid && in_ready;
   assign shamt = in_b[SHAMT_W-1:0];
   assign step = rem < STEP ? rem : STEP;
   // the single comb unit serves new operands at accept and the working register while shifting
   always_comb begin
      c_op = in_shift ? op_r : alu_op;
      c_a = in_shift ? work : in_a;
      c_amt = in_shift ? step : '0;
   end
   alu_comb #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_comb (
      .op(c_op), .a(c_a), .b(in_b), .amt(c_amt), .y(y)
   );
   // handshake FSM: single-cycle ops go straight to DONE, nonzero shifts iterate in SHIFT
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         result <= '0;
         illegal_op <= 1'b0;
         work <= '0;
         rem <= '0;
         op_r <= '0;
      end else begin
         case (state)
            SHIFT: begin
               work <= y;
               rem <= rem - step;
               if (rem == step) begin
                  result <= y;
                  illegal_op <= 1'b0;
                  state <= DONE;
               end
            end
            default: begin
               if (accept && is_shift_op(alu_op) && shamt != '0) begin
                  work <= in_a;
                  rem <= shamt;
                  op_r <= alu_op;
                  state <= SHIFT;
               end else if (accept) begin
                  result <= y;
                  illegal_op <= !is_legal_op(alu_op);
                  state <= DONE;
               end else if (state == DONE && out_ready) begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed checks of the multi-cycle ALU at two shift step sizes
bind alu_multicycle alu_multicycle_sva #(.WIDTH(WIDTH)) u_sva (
   .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op),
   .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
   .result(result), .zero(zero), .illegal_op(illegal_op), .in_shift(in_shift)
);

module tb_alu_multicycle;
   import alu_pkg::*;
   logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
   logic [3:0] alu_op = 4'h0;
   logic [31:0] in_a = '0, in_b = '0;
   logic in_ready, out_valid, zero, illegal_op;
   logic [31:0] result;
   logic in_ready4, out_valid4, zero4, illegal_op4;
   logic [31:0] result4;
   int n_checks = 0, n_errors = 0;
   int lat, lat4, busy;
   logic [31:0] res4;
   always #5 clk = ~clk;
   alu_multicycle #(.WIDTH(32), .SHIFT_STEP(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .illegal_op(illegal_op)
   );
   alu_multicycle #(.WIDTH(32), .SHIFT_STEP(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .alu_op(alu_op),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid4), .out_ready(out_ready),
      .result(result4), .zero(zero4), .illegal_op(illegal_op4)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int l);
      @(negedge clk);
      alu_op = op; in_a = a; in_b = b; in_valid = 1;
      @(negedge clk);
      in_valid = 0;
      l = 1;
      while (!out_valid && l < 64) begin
         @(negedge clk);
         l++;
      end
   endtask
   initial begin
      repeat (2) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 0);
      check("rst_result", result, 0);
      check("rst_zero", 32'(zero), 1);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_illegal", 32'(illegal_op), 0);
      rst = 0;
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 1);
      run_op(OP_ADD, 32'h5, 32'h3, lat);
      check("add_lat", lat, 1);
      check("add_res", result, 32'h8);
      check("add_zero", 32'(zero), 0);
      run_op(OP_SUB, 32'h10, 32'h10, lat);
      check("sub_eq_res", result, 0);
      check("sub_eq_zero", 32'(zero), 1);
      run_op(OP_SUB, 32'h0, 32'h1, lat);
      check("sub_wrap_res", result, 32'hFFFF_FFFF);
      check("sub_wrap_zero", 32'(zero), 0);
      run_op(OP_XOR, 32'hA5A5_A5A5, 32'hFFFF_0000, lat);
      check("xor_res", result, 32'h5A5A_A5A5);
      run_op(OP_OR, 32'h0F00, 32'h00F0, lat);
      check("or_res", result, 32'h0FF0);
      run_op(OP_SLTU, 32'h1, 32'hFFFF_FFFF, lat);
      check("sltu_lt", result, 1);
      run_op(OP_SLTU, 32'hFFFF_FFFF, 32'h1, lat);
      check("sltu_ge", result, 0);
      run_op(OP_SLT, 32'h8000_0000, 32'h1, lat);
      check("slt_neg", result, 1);
      run_op(OP_SRL, 32'h1234_5678, 32'd32, lat);
      check("srl0_lat", lat, 1);
      check("srl0_res", result, 32'h1234_5678);
      run_op(OP_SRL, 32'h8000_0000, 32'd3, lat);
      check("srl3_lat", lat, 4);
      check("srl3_res", result, 32'h1000_0000);
      @(negedge clk);
      alu_op = OP_SRA; in_a = 32'h8000_0000; in_b = 32'd4; in_valid = 1;
      @(negedge clk);
      in_valid = 0; alu_op = OP_ADD; in_a = '0; in_b = '0;
      lat = 1; lat4 = 0; busy = 0; res4 = '0;
      while (!out_valid && lat < 64) begin
         if (!in_ready) busy++;
         if (out_valid4 && lat4 == 0) begin
            lat4 = lat;
            res4 = result4;
         end
         @(negedge clk);
         lat++;
      end
      check("sra_lat", lat, 5);
      check("sra_busy", busy, 4);
      check("sra_res", result, 32'hF800_0000);
      check("sra4_lat", lat4, 2);
      check("sra4_res", res4, 32'hF800_0000);
      @(negedge clk);
      out_ready = 0; alu_op = OP_SLT; in_a = 32'hFFFF_FFFF; in_b = 32'h1; in_valid = 1;
      @(negedge clk);
      alu_op = OP_ADD; in_a = 32'h7; in_b = 32'h7;
      for (int i = 0; i < 3; i++) begin
         check("bp_valid", 32'(out_valid), 1);
         check("bp_res", result, 1);
         check("bp_in_ready", 32'(in_ready), 0);
         @(negedge clk);
      end
      alu_op = OP_AND; in_a = 32'hF0F0_F0F0; in_b = 32'hFF00_FF00; out_ready = 1;
      #1;
      check("bp_release_ready", 32'(in_ready), 1);
      check("bp_release_res", result, 1);
      @(negedge clk);
      in_valid = 0;
      check("b2b_valid", 32'(out_valid), 1);
      check("b2b_and_res", result, 32'hF000_F000);
      run_op(4'hF, 32'hDEAD_BEEF, 32'h1, lat);
      check("ill_lat", lat, 1);
      check("ill_res", result, 0);
      check("ill_zero", 32'(zero), 1);
      check("ill_flag", 32'(illegal_op), 1);
      run_op(OP_ADD, 32'h1, 32'h1, lat);
      check("ill_clear", 32'(illegal_op), 0);
      check("ill_next_res", result, 2);
      @(negedge clk);
      alu_op = OP_SLL; in_a = 32'h1; in_b = 32'd10; in_valid = 1;
      @(negedge clk);
      in_valid = 0;
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      check("abort_valid", 32'(out_valid), 0);
      check("abort_res", result, 0);
      check("abort_zero", 32'(zero), 1);
      check("abort_in_ready", 32'(in_ready), 0);
      rst = 0;
      @(negedge clk);
      check("abort_idle_ready", 32'(in_ready), 1);
      run_op(OP_SLL, 32'h1, 32'd31, lat);
      check("sll31_lat", lat, 32);
      check("sll31_res", result, 32'h8000_0000);
      check("sll31_res4", result4, 32'h8000_0000);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
